ctrl_unit: RTL and testbench

Moore control sequencer for the 16-bit accumulator CPU. Consumes the 3-bit `code_op` produced by the instruction register and the carry flag. Drives the load/enable strobes for the instruction register, program counter, accumulator, carry flag, ALU select and data memory. Sits between the instruction register and the datapath and advances one state per enabled clock.

---
 rtl/ctrl_unit.sv | 121 ++++++++++++
 tb/tb_ctrl_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_unit
// Purpose  : Moore control sequencer for the 16-bit accumulator CPU.
//            Define UT_CTRL_HALT_EN to make opcode 111 a halt instead of a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [2:0] code_op,
    input  logic       carry,
    output logic       load_RI,
    output logic       inc_PC,
    output logic       load_PC,
    output logic       en_mem,
    output logic       we_mem,
    output logic       sel_adr,
    output logic       load_ACC,
    output logic       load_carry,
    output logic       clr_carry,
    output logic [1:0] sel_ual,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_LOAD_RI = 4'd2,
        S_DECODE  = 4'd3,
        S_MEM_RD  = 4'd4,
        S_EXEC    = 4'd5,
        S_STORE   = 4'd6,
        S_JUMP    = 4'd7,
        S_CLRC    = 4'd8
`ifdef UT_CTRL_HALT_EN
        , S_HALT  = 4'd9
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    state_d = S_FETCH;
            S_FETCH:   state_d = S_LOAD_RI;
            S_LOAD_RI: state_d = S_DECODE;
            S_DECODE: begin
                case (code_op)
                    3'b000, 3'b001, 3'b010, 3'b011: state_d = S_MEM_RD;
                    3'b100:  state_d = S_STORE;
                    3'b101:  state_d = S_JUMP;
                    // JCC: jump only when the carry flag is clear
                    3'b110:  state_d = carry ? S_CLRC : S_JUMP;
`ifdef UT_CTRL_HALT_EN
                    default: state_d = S_HALT;
`else
                    default: state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_RD:  state_d = S_EXEC;
            S_EXEC, S_STORE, S_JUMP, S_CLRC: state_d = S_FETCH;
            default:   state_d = state_q;
        endcase
    end

    always_comb begin
        load_RI    = 1'b0;
        inc_PC     = 1'b0;
        load_PC    = 1'b0;
        en_mem     = 1'b0;
        we_mem     = 1'b0;
        sel_adr    = 1'b0;
        load_ACC   = 1'b0;
        load_carry = 1'b0;
        clr_carry  = 1'b0;
        sel_ual    = 2'b00;
        halted     = 1'b0;
        case (state_q)
            S_FETCH:   en_mem = 1'b1;
            S_LOAD_RI: begin
                load_RI = 1'b1;
                inc_PC  = 1'b1;
            end
            S_MEM_RD: begin
                en_mem  = 1'b1;
                sel_adr = 1'b1;
            end
            S_EXEC: begin
                load_ACC   = 1'b1;
                sel_ual    = code_op[1:0];
                load_carry = (code_op == 3'b001) || (code_op == 3'b010);
            end
            S_STORE: begin
                en_mem  = 1'b1;
                we_mem  = 1'b1;
                sel_adr = 1'b1;
            end
            S_JUMP:    load_PC   = 1'b1;
            S_CLRC:    clr_carry = 1'b1;
`ifdef UT_CTRL_HALT_EN
            S_HALT:    halted    = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_unit
// Purpose  : Self-checking bench for ctrl_unit (vector table, directed
//            corner cases, randomized run against an instruction-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_unit;

`ifdef UT_CTRL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // Output vector: {load_RI,inc_PC,load_PC,en_mem,we_mem,sel_adr,
    //                 load_ACC,load_carry,clr_carry,sel_ual[1:0],halted}
    localparam logic [11:0] O_NONE  = 12'h000;
    localparam logic [11:0] O_FETCH = 12'h100;
    localparam logic [11:0] O_LRI   = 12'hC00;
    localparam logic [11:0] O_MRD   = 12'h140;
    localparam logic [11:0] O_STORE = 12'h1C0;
    localparam logic [11:0] O_JUMP  = 12'h200;
    localparam logic [11:0] O_CLRC  = 12'h008;
    localparam logic [11:0] O_HALT  = 12'h001;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [2:0] code_op;
    logic       carry;
    logic       load_RI, inc_PC, load_PC, en_mem, we_mem, sel_adr;
    logic       load_ACC, load_carry, clr_carry, halted;
    logic [1:0] sel_ual;
    logic [11:0] outs;

    ctrl_unit dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .code_op    (code_op),
        .carry      (carry),
        .load_RI    (load_RI),
        .inc_PC     (inc_PC),
        .load_PC    (load_PC),
        .en_mem     (en_mem),
        .we_mem     (we_mem),
        .sel_adr    (sel_adr),
        .load_ACC   (load_ACC),
        .load_carry (load_carry),
        .clr_carry  (clr_carry),
        .sel_ual    (sel_ual),
        .halted     (halted)
    );

    assign outs = {load_RI, inc_PC, load_PC, en_mem, we_mem, sel_adr,
                   load_ACC, load_carry, clr_carry, sel_ual, halted};

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        ce;
        logic [2:0]  op;
        logic        cy;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [0:29];

    // Instruction-level model: position within the current instruction
    int   m_k;
    bit   m_init;
    bit   m_halt;
    bit   m_jcc_taken;

    function automatic logic [11:0] exec_out(input logic [2:0] op);
        logic [11:0] v;
        v = 12'h020;
        v[2:1] = op[1:0];
        if (op == 3'd1 || op == 3'd2) v[4] = 1'b1;
        return v;
    endfunction

    function automatic int instr_len(input logic [2:0] op);
        if (op < 3'd4)  return 5;
        if (op == 3'd7) return 3;
        return 4;
    endfunction

    function automatic logic [11:0] model_out();
        if (m_init) return O_NONE;
        if (m_halt) return O_HALT;
        case (m_k)
            0: return O_FETCH;
            1: return O_LRI;
            2: return O_NONE;
            3: begin
                if (code_op < 3'd4)  return O_MRD;
                if (code_op == 3'd4) return O_STORE;
                if (code_op == 3'd5) return O_JUMP;
                if (code_op == 3'd6) return m_jcc_taken ? O_JUMP : O_CLRC;
                return O_NONE;
            end
            default: return exec_out(code_op);
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_init = 1'b1;
            m_halt = 1'b0;
            m_k    = 0;
        end else if (ce) begin
            if (m_init) begin
                m_init = 1'b0;
                m_k    = 0;
            end else if (!m_halt) begin
                if (m_k == 2) m_jcc_taken = !carry;
                if (m_k == 2 && code_op == 3'd7 && HALT_EN) begin
                    m_halt = 1'b1;
                end else if (m_k + 1 == instr_len(code_op)) begin
                    m_k = 0;
                end else begin
                    m_k = m_k + 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %03h expected %03h", name, got, exp);
        end
    endtask

    task automatic tick(input logic c, input logic [2:0] o, input logic cy);
        ce      = c;
        code_op = o;
        carry   = cy;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic c, input logic [2:0] o, input logic cy,
                                input logic [11:0] e);
        vec_t v;
        v.ce = c; v.op = o; v.cy = cy; v.exp = e;
        return v;
    endfunction

    initial begin
        logic       r_rst, r_ce, r_cy;
        logic [2:0] r_op;

        vecs[0]  = mk(1, 3'd1, 0, O_FETCH);
        vecs[1]  = mk(1, 3'd1, 0, O_LRI);
        vecs[2]  = mk(1, 3'd1, 0, O_NONE);
        vecs[3]  = mk(1, 3'd1, 0, O_MRD);
        vecs[4]  = mk(1, 3'd1, 0, 12'h032);
        vecs[5]  = mk(1, 3'd1, 0, O_FETCH);
        vecs[6]  = mk(1, 3'd4, 0, O_LRI);
        vecs[7]  = mk(1, 3'd4, 0, O_NONE);
        vecs[8]  = mk(1, 3'd4, 0, O_STORE);
        vecs[9]  = mk(1, 3'd4, 0, O_FETCH);
        vecs[10] = mk(1, 3'd6, 0, O_LRI);
        vecs[11] = mk(1, 3'd6, 0, O_NONE);
        vecs[12] = mk(1, 3'd6, 0, O_JUMP);
        vecs[13] = mk(1, 3'd6, 1, O_FETCH);
        vecs[14] = mk(1, 3'd6, 1, O_LRI);
        vecs[15] = mk(1, 3'd6, 1, O_NONE);
        vecs[16] = mk(1, 3'd6, 1, O_CLRC);
        vecs[17] = mk(1, 3'd3, 0, O_FETCH);
        vecs[18] = mk(1, 3'd3, 0, O_LRI);
        vecs[19] = mk(1, 3'd3, 0, O_NONE);
        vecs[20] = mk(0, 3'd3, 0, O_NONE);
        vecs[21] = mk(1, 3'd3, 0, O_MRD);
        vecs[22] = mk(1, 3'd3, 0, 12'h026);
        vecs[23] = mk(0, 3'd3, 0, 12'h026);
        vecs[24] = mk(0, 3'd3, 0, 12'h026);
        vecs[25] = mk(1, 3'd3, 0, O_FETCH);
        vecs[26] = mk(1, 3'd5, 0, O_LRI);
        vecs[27] = mk(1, 3'd5, 0, O_NONE);
        vecs[28] = mk(1, 3'd5, 0, O_JUMP);
        vecs[29] = mk(1, 3'd5, 0, O_FETCH);

        rst = 1'b1; ce = 1'b0; code_op = 3'd0; carry = 1'b0;
        @(negedge clk);
        check("reset", outs, O_NONE);
        rst = 1'b0;
        tick(0, 3'd1, 0);
        check("init_hold", outs, O_NONE);

        for (int i = 0; i < 30; i++) begin
            tick(vecs[i].ce, vecs[i].op, vecs[i].cy);
            check($sformatf("vec%0d", i), outs, vecs[i].exp);
        end

        // Reset while in MEM_RD: outputs clear at once, then restart
        tick(1, 3'd0, 0);
        tick(1, 3'd0, 0);
        tick(1, 3'd0, 0);
        check("mrd_before_rst", outs, O_MRD);
        rst = 1'b1;
        #1;
        check("rst_async", outs, O_NONE);
        tick(1, 3'd0, 0);
        check("rst_held", outs, O_NONE);
        rst = 1'b0;
        tick(1, 3'd0, 0);
        check("restart_fetch", outs, O_FETCH);

        // Opcode 111
        tick(1, 3'd7, 0);
        tick(1, 3'd7, 0);
        check("hlt_decode", outs, O_NONE);
        tick(1, 3'd7, 0);
        if (HALT_EN) begin
            check("halt_enter", outs, O_HALT);
            for (int i = 0; i < 20; i++) begin
                tick(1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                check("halt_stay", outs, O_HALT);
            end
        end else begin
            check("nop_fetch", outs, O_FETCH);
        end

        rst = 1'b1;
        tick(1, 3'd0, 0);
        rst = 1'b0;
        m_init = 1'b1; m_halt = 1'b0; m_k = 0; m_jcc_taken = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            check("rand", outs, model_out());
            r_rst = ($urandom_range(0, 63) == 0);
            r_ce  = ($urandom_range(0, 3) != 0);
            r_cy  = 1'($urandom_range(0, 1));
            if (m_init || (!m_halt && m_k == 1)) r_op = 3'($urandom_range(0, 7));
            else                                  r_op = code_op;
            rst = r_rst; ce = r_ce; carry = r_cy; code_op = r_op;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
